// File: rtl/sonic_ranger_ctrl.sv
// Ultrasonic ranging sequencer: trigger, echo timing, cm conversion and BCD split on one shared divider.
// Define SONIC_AVG4_EN to average four successful echo widths before each conversion.

module sonic_ranger_ctrl #(
  parameter int TICK_DIV   = 50,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int PERIOD_US  = 60000,
  parameter int ALARM_CM   = 10
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       en,
  input  logic       echo,
  output logic       trig,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [9:0] dist_cm,
  output logic [3:0] centaine,
  output logic [3:0] dizaine,
  output logic [3:0] unite,
  output logic       led_near
);

  localparam logic [15:0] TICK_LAST    = 16'(TICK_DIV - 1);
  localparam logic [15:0] TRIG_LAST    = 16'(TRIG_US - 1);
  localparam logic [15:0] TOUT_LAST    = 16'(TIMEOUT_US - 1);
  localparam logic [15:0] PERIOD_TICKS = 16'(PERIOD_US);
  localparam logic [9:0]  ALARM_THR    = 10'(ALARM_CM);

  typedef enum logic [3:0] {
    IDLE, TRIG, WAIT_RISE, MEASURE, DIV_CM, DIV_U, DIV_D, DONE, TOUT, HOLDOFF
  } state_e;

  state_e      state_q;
  logic [15:0] presc_q, presc_d;
  logic        echo_meta_q, echo_s_q;
  logic [15:0] us_q, width_q, period_q, meas_q;
  logic [15:0] quo_q;
  logic [6:0]  rem_q;
  logic [4:0]  div_cnt_q;
  logic [9:0]  cm_q, q1_q;
  logic [3:0]  unite_q;

  logic        tick, div_active, div_last, div_ge, tout_hit;
  logic [6:0]  divisor, div_rem_n;
  logic [7:0]  div_shift;
  logic [15:0] div_quo_n, div_src;
  logic [9:0]  cm_clamped;

`ifdef SONIC_AVG4_EN
  logic [17:0] acc_q, sum_n;
  logic [1:0]  avg_cnt_q;
`endif

  always_comb begin
    tick       = (presc_q == TICK_LAST);
    presc_d    = tick ? 16'd0 : presc_q + 16'd1;
    div_active = (state_q == DIV_CM) || (state_q == DIV_U) || (state_q == DIV_D);
    div_last   = div_active && (div_cnt_q == 5'd16);
    divisor    = (state_q == DIV_CM) ? 7'd58 : 7'd10;
    case (state_q)
      DIV_U:   div_src = {6'd0, cm_q};
      DIV_D:   div_src = {6'd0, q1_q};
      default: div_src = meas_q;
    endcase
    // Restoring step: the shifted partial remainder never exceeds 2*divisor-1, so 8 bits suffice.
    div_shift  = {rem_q, quo_q[15]};
    div_ge     = (div_shift >= {1'b0, divisor});
    div_rem_n  = div_ge ? 7'(div_shift - {1'b0, divisor}) : div_shift[6:0];
    div_quo_n  = {quo_q[14:0], div_ge};
    cm_clamped = (div_quo_n > 16'd999) ? 10'd999 : div_quo_n[9:0];
    tout_hit   = tick && (((state_q == WAIT_RISE) && !echo_s_q && (us_q == TOUT_LAST)) ||
                          ((state_q == MEASURE) && echo_s_q && (width_q == TOUT_LAST)));
`ifdef SONIC_AVG4_EN
    sum_n      = acc_q + {2'b00, width_q};
`endif
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      presc_q     <= '0;
      echo_meta_q <= 1'b0;
      echo_s_q    <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      echo_meta_q <= echo;
      echo_s_q    <= echo_meta_q;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q   <= IDLE;
      us_q      <= '0;
      width_q   <= '0;
      period_q  <= '0;
      meas_q    <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      div_cnt_q <= '0;
      cm_q      <= '0;
      q1_q      <= '0;
      unite_q   <= '0;
      trig      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      dist_cm   <= '0;
      centaine  <= '0;
      dizaine   <= '0;
      unite     <= '0;
      led_near  <= 1'b0;
`ifdef SONIC_AVG4_EN
      acc_q     <= '0;
      avg_cnt_q <= '0;
`endif
    end else begin
      done <= 1'b0;
      if ((state_q != IDLE) && tick) period_q <= period_q + 16'd1;

      if (div_active) begin
        if (div_cnt_q == 5'd0) begin
          quo_q <= div_src;
          rem_q <= '0;
        end else begin
          quo_q <= div_quo_n;
          rem_q <= div_rem_n;
        end
        div_cnt_q <= div_last ? 5'd0 : div_cnt_q + 5'd1;
      end

      case (state_q)
        IDLE: begin
          period_q <= '0;
          if (en) begin
            state_q <= TRIG;
            trig    <= 1'b1;
            busy    <= 1'b1;
            us_q    <= '0;
          end
        end
        TRIG: begin
          if (tick) begin
            if (us_q == TRIG_LAST) begin
              state_q <= WAIT_RISE;
              trig    <= 1'b0;
              us_q    <= '0;
            end else begin
              us_q <= us_q + 16'd1;
            end
          end
        end
        WAIT_RISE: begin
          if (echo_s_q) begin
            state_q <= MEASURE;
            width_q <= '0;
          end else if (tick) begin
            us_q <= us_q + 16'd1;
          end
        end
        MEASURE: begin
          if (!echo_s_q) begin
            div_cnt_q <= '0;
`ifdef SONIC_AVG4_EN
            if (avg_cnt_q == 2'd3) begin
              meas_q    <= sum_n[17:2];
              acc_q     <= '0;
              avg_cnt_q <= '0;
              state_q   <= DIV_CM;
            end else begin
              acc_q     <= sum_n;
              avg_cnt_q <= avg_cnt_q + 2'd1;
              state_q   <= HOLDOFF;
            end
`else
            meas_q  <= width_q;
            state_q <= DIV_CM;
`endif
          end else if (tick) begin
            width_q <= width_q + 16'd1;
          end
        end
        DIV_CM: begin
          if (div_last) begin
            cm_q    <= cm_clamped;
            state_q <= DIV_U;
          end
        end
        DIV_U: begin
          if (div_last) begin
            unite_q <= div_rem_n[3:0];
            q1_q    <= div_quo_n[9:0];
            state_q <= DIV_D;
          end
        end
        DIV_D: begin
          // Results and done are registered together so they appear on the same edge.
          if (div_last) begin
            dist_cm  <= cm_q;
            centaine <= div_quo_n[3:0];
            dizaine  <= div_rem_n[3:0];
            unite    <= unite_q;
            timeout  <= 1'b0;
            led_near <= (cm_q < ALARM_THR);
            done     <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE:    state_q <= HOLDOFF;
        TOUT:    state_q <= HOLDOFF;
        HOLDOFF: begin
          if (period_q >= PERIOD_TICKS) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (tout_hit) begin
        state_q  <= TOUT;
        dist_cm  <= 10'd999;
        centaine <= 4'd9;
        dizaine  <= 4'd9;
        unite    <= 4'd9;
        timeout  <= 1'b1;
        led_near <= 1'b0;
        done     <= 1'b1;
`ifdef SONIC_AVG4_EN
        acc_q     <= '0;
        avg_cnt_q <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sonic_ranger_ctrl.sv
// Directed bench for sonic_ranger_ctrl with shortened timing parameters.
// With SONIC_AVG4_EN defined the averaging sequence replaces the single-shot sequence.

module tb_sonic_ranger_ctrl;

  localparam int TICK_DIV   = 2;
  localparam int TRIG_US    = 10;
  localparam int TIMEOUT_US = 1500;
  localparam int PERIOD_US  = 2500;
  localparam int ALARM_CM   = 10;
  localparam int PERIOD_CYC = PERIOD_US * TICK_DIV;
  localparam int TOUT_CYC   = TIMEOUT_US * TICK_DIV;

  logic       clk_50m = 1'b0;
  logic       rst, en, echo;
  logic       trig, busy, done, timeout, led_near;
  logic [9:0] dist_cm;
  logic [3:0] centaine, dizaine, unite;

  int checks = 0, passCount = 0, failCount = 0;
  int cyc = 0, trigRises = 0, doneCount = 0;
  logic trigPrev = 1'b0;

  sonic_ranger_ctrl #(
    .TICK_DIV(TICK_DIV), .TRIG_US(TRIG_US), .TIMEOUT_US(TIMEOUT_US),
    .PERIOD_US(PERIOD_US), .ALARM_CM(ALARM_CM)
  ) dut (
    .clk_50m(clk_50m), .rst(rst), .en(en), .echo(echo),
    .trig(trig), .busy(busy), .done(done), .timeout(timeout),
    .dist_cm(dist_cm), .centaine(centaine), .dizaine(dizaine), .unite(unite),
    .led_near(led_near)
  );

  always #10 clk_50m = ~clk_50m;

  always @(negedge clk_50m) begin
    cyc = cyc + 1;
    if (trig === 1'b1 && trigPrev === 1'b0) trigRises = trigRises + 1;
    trigPrev = trig;
    if (done === 1'b1) doneCount = doneCount + 1;
  end

  initial begin
    #(200_000 * 20);
    $display("[TB] FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkResult(input int d, input int c, input int z, input int u, input int t, input int l);
    checkOutput("dist_cm", 32'(dist_cm), d);
    checkOutput("centaine", 32'(centaine), c);
    checkOutput("dizaine", 32'(dizaine), z);
    checkOutput("unite", 32'(unite), u);
    checkOutput("timeout", 32'(timeout), t);
    checkOutput("led_near", 32'(led_near), l);
  endtask

  task automatic waitTrig(input logic level, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_50m); #1;
      if (trig === level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitDone(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk_50m); #1;
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Waits for the next trigger, then drives an echo pulse of echoCycles clocks; returns at #1 after the falling drive.
  task automatic applyStimulus(input int echoCycles, input bit dropEn, output int riseCyc);
    bit ok;
    waitTrig(1'b1, PERIOD_CYC + 200, ok);
    riseCyc = cyc;
    checkOutput("trig_rise_seen", 32'(ok), 1);
    waitTrig(1'b0, 100, ok);
    checkOutput("trig_fall_seen", 32'(ok), 1);
    if (dropEn) en = 1'b0;
    repeat (6) @(posedge clk_50m);
    #1 echo = 1'b1;
    repeat (echoCycles) @(posedge clk_50m);
    #1 echo = 1'b0;
  endtask

  initial begin
    int lat, r1, r2, r3, r4, n0, d0, diff;
    bit ok;
    rst = 1'b1; en = 1'b0; echo = 1'b0;
    repeat (3) @(posedge clk_50m);
    #1;
    checkOutput("rst_trig", 32'(trig), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkResult(0, 0, 0, 0, 0, 0);

    rst = 1'b0; en = 1'b1;
    @(posedge clk_50m); #1;
    checkOutput("trig_after_en", 32'(trig), 1);
    checkOutput("busy_after_en", 32'(busy), 1);

`ifdef SONIC_AVG4_EN
    d0 = doneCount;
    applyStimulus(1161, 1'b0, r1);
    applyStimulus(1161, 1'b0, r1);
    applyStimulus(2321, 1'b0, r1);
    applyStimulus(2321, 1'b0, r1);
    waitDone(200, lat);
    checkOutput("avg_done_latency", 32'(lat), 54);
    @(negedge clk_50m); #1;
    checkOutput("avg_done_count", 32'(doneCount - d0), 1);
    checkResult(15, 0, 1, 5, 0, 0);
`else
    // 580 us echo: 580 ticks, exactly 10 cm
    applyStimulus(1161, 1'b0, r1);
    waitDone(200, lat);
    checkOutput("latency_580us", 32'(lat), 54);
    checkResult(10, 0, 1, 0, 0, 0);
    @(posedge clk_50m); #1;
    checkOutput("done_width", 32'(done), 0);

    // 57 us echo rounds down to 0 cm and lights the proximity LED
    applyStimulus(114, 1'b0, r2);
    waitDone(200, lat);
    checkOutput("latency_57us", 32'(lat), 54);
    checkResult(0, 0, 0, 0, 0, 1);

    // No echo: timeout reported TIMEOUT_US after WAIT_RISE entry
    waitTrig(1'b1, PERIOD_CYC + 200, ok);
    r3 = cyc;
    checkOutput("tout_trig_rise", 32'(ok), 1);
    diff = r3 - r2;
    checkOutput("period_after_meas", 32'(diff >= PERIOD_CYC - 4 && diff <= PERIOD_CYC + TICK_DIV + 4), 1);
    waitTrig(1'b0, 100, ok);
    checkOutput("tout_trig_fall", 32'(ok), 1);
    waitDone(TOUT_CYC + 100, lat);
    checkOutput("tout_latency", 32'(lat >= TOUT_CYC - TICK_DIV - 2 && lat <= TOUT_CYC + TICK_DIV + 2), 1);
    checkResult(999, 9, 9, 9, 1, 0);
    waitTrig(1'b1, PERIOD_CYC + 200, ok);
    r4 = cyc;
    checkOutput("trig_after_tout", 32'(ok), 1);
    diff = r4 - r3;
    checkOutput("period_after_tout", 32'(diff >= PERIOD_CYC - 4 && diff <= PERIOD_CYC + TICK_DIV + 4), 1);

    // Reset in the middle of MEASURE aborts everything
    waitTrig(1'b0, 100, ok);
    checkOutput("rst_test_trig_fall", 32'(ok), 1);
    repeat (6) @(posedge clk_50m);
    #1 echo = 1'b1;
    repeat (100) @(posedge clk_50m);
    #1;
    checkOutput("busy_in_measure", 32'(busy), 1);
    d0 = doneCount;
    rst = 1'b1;
    @(posedge clk_50m); #1;
    checkOutput("midrst_busy", 32'(busy), 0);
    checkOutput("midrst_trig", 32'(trig), 0);
    checkOutput("midrst_done", 32'(done), 0);
    checkResult(0, 0, 0, 0, 0, 0);
    echo = 1'b0;
    rst = 1'b0;
    @(posedge clk_50m); #1;
    checkOutput("trig_after_rst", 32'(trig), 1);
    checkOutput("no_done_on_rst", 32'(doneCount - d0), 0);

    // en dropped in WAIT_RISE: this measurement completes, then the block parks in IDLE
    applyStimulus(2321, 1'b1, r1);
    waitDone(200, lat);
    checkOutput("latency_1160us", 32'(lat), 54);
    checkResult(20, 0, 2, 0, 0, 0);
    n0 = trigRises;
    repeat (3 * PERIOD_CYC) @(posedge clk_50m);
    #1;
    checkOutput("no_trig_after_en_low", 32'(trigRises - n0), 0);
    checkOutput("idle_busy", 32'(busy), 0);
`endif

    $display("%0d/%0d checks passed", passCount, checks);
    $finish;
  end

endmodule
